// File: rtl/dac_sample_sequencer.sv
// rtl/dac_sample_sequencer.sv - PCM sample FIFO and pacing front end for the sigma-delta DAC
//
// Accepts PCM samples over a valid/ready handshake into a small FIFO and
// presents one sample on dac_din every 2**OSR_LOG2 clocks. Playback starts
// once PRIME_LEVEL samples are buffered. An empty FIFO at a sample boundary
// holds the last output and flags underrun. Dropping enable ramps dac_din
// to midscale in RAMP_STEP increments before returning to idle, so muting
// never produces a step at the DAC output.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active-high
//   enable       in   1 = play, 0 = ramp to midscale then idle
//   s_data       in   [WIDTH-1:0] input sample (offset binary)
//   s_valid      in   s_data valid
//   s_ready      out  FIFO accepts s_data this cycle
//   dac_din      out  [WIDTH-1:0] registered sample to the DAC
//   sample_tick  out  one-cycle pulse at every sample boundary
//   underrun     out  one-cycle pulse: sample boundary hit with FIFO empty
//   fifo_level   out  [$clog2(FIFO_DEPTH):0] current FIFO occupancy
//   active       out  state is RUN or RAMP

module dac_sample_sequencer #(
  parameter int WIDTH       = 16,
  parameter int OSR_LOG2    = 10,
  parameter int FIFO_DEPTH  = 4,
  parameter int PRIME_LEVEL = 2,
  parameter int RAMP_STEP   = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [WIDTH-1:0]              s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [WIDTH-1:0]              dac_din,
  output logic                          sample_tick,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          active
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [WIDTH-1:0] MID       = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] STEP      = WIDTH'(RAMP_STEP);
  localparam logic [AW:0]      FULL_LVL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]      PRIME_LVL = (AW+1)'(PRIME_LEVEL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_RAMP
  } state_t;

  state_t state, state_next;

  logic [OSR_LOG2-1:0] counter;
  logic                tick;
  logic                running;

  logic [WIDTH-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         level;
  logic                full;
  logic                empty;

  logic                push;
  logic                pop;
  logic                flush;
  logic                starve;
  logic                ramp_tick;
  logic [WIDTH-1:0]    ramp_val;

  assign running    = (state == S_RUN) || (state == S_RAMP);
  // The counter is held at zero outside RUN/RAMP, but on the first cycle
  // after leaving RAMP it still carries the last increment, so the boundary
  // is qualified with the state.
  assign tick       = running && (&counter);
  assign full       = (level == FULL_LVL);
  assign empty      = (level == '0);
  assign fifo_level = level;
  assign active     = running;

  // Step toward midscale without passing it; the distance test happens
  // before the add/subtract, so neither direction can wrap.
  always_comb begin
    ramp_val = dac_din;
    if (dac_din > MID) begin
      if ((dac_din - MID) <= STEP) ramp_val = MID;
      else                         ramp_val = dac_din - STEP;
    end else begin
      if ((MID - dac_din) <= STEP) ramp_val = MID;
      else                         ramp_val = dac_din + STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    flush      = 1'b0;
    starve     = 1'b0;
    ramp_tick  = 1'b0;
    // rst is folded in so the source sees no ready while reset is held,
    // even though the state register already reads IDLE.
    s_ready    = !rst && enable && !full && (state != S_RAMP);
    push       = s_valid && s_ready;

    case (state)
      S_IDLE: begin
        if (enable) state_next = S_PRIME;
      end
      S_PRIME: begin
        if (!enable)                  state_next = S_RAMP;
        else if (level >= PRIME_LVL)  state_next = S_RUN;
      end
      S_RUN: begin
        // Mute wins over the boundary: the sample due now is not played.
        if (!enable) begin
          state_next = S_RAMP;
        end else if (tick) begin
          if (empty) starve = 1'b1;
          else       pop    = 1'b1;
        end
      end
      S_RAMP: begin
        if (dac_din == MID) begin
          state_next = S_IDLE;
          flush      = 1'b1;
        end else if (tick) begin
          ramp_tick = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
    end else if (running) begin
      counter <= counter + 1'b1;
    end else begin
      counter <= '0;
    end
  end

  // Storage carries no reset; occupancy is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac_din     <= MID;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      sample_tick <= tick;
      underrun    <= starve;
      if (pop)                  dac_din <= mem[rd_ptr];
      else if (ramp_tick)       dac_din <= ramp_val;
      else if (state == S_IDLE) dac_din <= MID;
    end
  end

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// tb/tb_dac_sample_sequencer.sv - directed bench for dac_sample_sequencer

module tb_dac_sample_sequencer;

  logic        clk = 1'b0;
  logic        rst;

  logic        en_a, sv_a, sr_a, tick_a, ur_a, act_a;
  logic [15:0] sd_a, din_a;
  logic [2:0]  lvl_a;

  logic        en_b, sv_b, sr_b, tick_b, ur_b, act_b;
  logic [15:0] sd_b, din_b;
  logic [2:0]  lvl_b;

  int          checks = 0;
  int          fails  = 0;
  logic [15:0] wrap_data [1000];

  always #5 clk = ~clk;

  // Default rates: 1024 clocks per sample.
  dac_sample_sequencer dut_a (
    .clk         (clk),
    .rst         (rst),
    .enable      (en_a),
    .s_data      (sd_a),
    .s_valid     (sv_a),
    .s_ready     (sr_a),
    .dac_din     (din_a),
    .sample_tick (tick_a),
    .underrun    (ur_a),
    .fifo_level  (lvl_a),
    .active      (act_a)
  );

  // Fast instance (16 clocks per sample) for the long ramp and streaming runs.
  dac_sample_sequencer #(.OSR_LOG2(4)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .enable      (en_b),
    .s_data      (sd_b),
    .s_valid     (sv_b),
    .s_ready     (sr_b),
    .dac_din     (din_b),
    .sample_tick (tick_b),
    .underrun    (ur_b),
    .fifo_level  (lvl_b),
    .active      (act_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_tick_a(output int cyc);
    cyc = 0;
    do begin step(); cyc++; end while (tick_a !== 1'b1 && cyc < 3000);
    if (tick_a !== 1'b1) begin
      cyc = -1; checks++; fails++;
      $display("FAIL wait_tick_a: no sample_tick within 3000 clocks");
    end
  endtask

  task automatic wait_tick_b(output int cyc);
    cyc = 0;
    do begin step(); cyc++; end while (tick_b !== 1'b1 && cyc < 100);
    if (tick_b !== 1'b1) begin
      cyc = -1; checks++; fails++;
      $display("FAIL wait_tick_b: no sample_tick within 100 clocks");
    end
  endtask

  task automatic push_a(input logic [15:0] d);
    bit acc, ok;
    ok = 1'b0; sv_a = 1'b1; sd_a = d;
    for (int k = 0; k < 3000 && !ok; k++) begin
      #1; acc = sr_a;
      @(posedge clk); #1;
      ok = acc;
    end
    sv_a = 1'b0;
    if (!ok) begin
      checks++; fails++;
      $display("FAIL push_a: sample %h not accepted within 3000 clocks", d);
    end
  endtask

  task automatic push_b(input logic [15:0] d, output bit ok);
    bit acc;
    ok = 1'b0; sv_b = 1'b1; sd_b = d;
    for (int k = 0; k < 3000 && !ok; k++) begin
      #1; acc = sr_b;
      @(posedge clk); #1;
      ok = acc;
    end
    sv_b = 1'b0;
    if (!ok) begin
      checks++; fails++;
      $display("FAIL push_b: sample %h not accepted within 3000 clocks", d);
    end
  endtask

  task automatic test_reset();
    step_n(3);
    checks++; if (din_a !== 16'h8000) begin fails++; $display("FAIL reset_din: got %h want 8000", din_a); end
    checks++; if (lvl_a !== 3'd0)     begin fails++; $display("FAIL reset_level: got %0d want 0", lvl_a); end
    checks++; if (sr_a !== 1'b0)      begin fails++; $display("FAIL reset_ready: got %b want 0", sr_a); end
    checks++; if (act_a !== 1'b0)     begin fails++; $display("FAIL reset_active: got %b want 0", act_a); end
    checks++; if (tick_a !== 1'b0)    begin fails++; $display("FAIL reset_tick: got %b want 0", tick_a); end
    checks++; if (ur_a !== 1'b0)      begin fails++; $display("FAIL reset_underrun: got %b want 0", ur_a); end
    rst = 1'b0;
  endtask

  task automatic test_startup();
    int n;
    push_a(16'h1234);
    push_a(16'h5678);
    n = 0;
    while (act_a !== 1'b1 && n < 20) begin step(); n++; end
    checks++; if (act_a !== 1'b1) begin fails++; $display("FAIL startup_active: got %b want 1", act_a); end
    checks++; if (lvl_a !== 3'd2) begin fails++; $display("FAIL startup_level: got %0d want 2", lvl_a); end
    step_n(1023);
    checks++; if (din_a !== 16'h8000) begin fails++; $display("FAIL startup_pre_din: got %h want 8000", din_a); end
    checks++; if (tick_a !== 1'b0)    begin fails++; $display("FAIL startup_pre_tick: got %b want 0", tick_a); end
    step();
    checks++; if (din_a !== 16'h1234) begin fails++; $display("FAIL startup_din1: got %h want 1234", din_a); end
    checks++; if (tick_a !== 1'b1)    begin fails++; $display("FAIL startup_tick1: got %b want 1", tick_a); end
    checks++; if (lvl_a !== 3'd1)     begin fails++; $display("FAIL startup_level1: got %0d want 1", lvl_a); end
    step_n(1023);
    checks++; if (din_a !== 16'h1234) begin fails++; $display("FAIL startup_hold: got %h want 1234", din_a); end
    checks++; if (tick_a !== 1'b0)    begin fails++; $display("FAIL startup_tick_gap: got %b want 0", tick_a); end
    step();
    checks++; if (din_a !== 16'h5678) begin fails++; $display("FAIL startup_din2: got %h want 5678", din_a); end
    checks++; if (tick_a !== 1'b1)    begin fails++; $display("FAIL startup_tick2: got %b want 1", tick_a); end
    checks++; if (lvl_a !== 3'd0)     begin fails++; $display("FAIL startup_level2: got %0d want 0", lvl_a); end
  endtask

  task automatic test_underrun();
    int n;
    push_a(16'hABCD);
    wait_tick_a(n);
    checks++; if (din_a !== 16'hABCD) begin fails++; $display("FAIL underrun_din1: got %h want abcd", din_a); end
    checks++; if (ur_a !== 1'b0)      begin fails++; $display("FAIL underrun_early: got %b want 0", ur_a); end
    wait_tick_a(n);
    checks++; if (n !== 1024)         begin fails++; $display("FAIL underrun_period: got %0d want 1024", n); end
    checks++; if (ur_a !== 1'b1)      begin fails++; $display("FAIL underrun_pulse: got %b want 1", ur_a); end
    checks++; if (din_a !== 16'hABCD) begin fails++; $display("FAIL underrun_hold: got %h want abcd", din_a); end
    step();
    checks++; if (ur_a !== 1'b0)      begin fails++; $display("FAIL underrun_width: got %b want 0", ur_a); end
    push_a(16'h4321);
    wait_tick_a(n);
    checks++; if (din_a !== 16'h4321) begin fails++; $display("FAIL underrun_recover: got %h want 4321", din_a); end
    checks++; if (ur_a !== 1'b0)      begin fails++; $display("FAIL underrun_recover_ur: got %b want 0", ur_a); end
  endtask

  task automatic test_reset_midrun();
    push_a(16'h7777);
    checks++; if (lvl_a !== 3'd1) begin fails++; $display("FAIL midrst_prelevel: got %0d want 1", lvl_a); end
    rst = 1'b1;
    #1;
    checks++; if (din_a !== 16'h8000) begin fails++; $display("FAIL midrst_din: got %h want 8000", din_a); end
    checks++; if (lvl_a !== 3'd0)     begin fails++; $display("FAIL midrst_level: got %0d want 0", lvl_a); end
    checks++; if (sr_a !== 1'b0)      begin fails++; $display("FAIL midrst_ready: got %b want 0", sr_a); end
    checks++; if (act_a !== 1'b0)     begin fails++; $display("FAIL midrst_active: got %b want 0", act_a); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_full();
    int n;
    push_a(16'h1111);
    push_a(16'h2222);
    push_a(16'h3333);
    push_a(16'h4444);
    checks++; if (lvl_a !== 3'd4) begin fails++; $display("FAIL full_level: got %0d want 4", lvl_a); end
    sv_a = 1'b1; sd_a = 16'h5555;
    #1;
    checks++; if (sr_a !== 1'b0) begin fails++; $display("FAIL full_ready: got %b want 0", sr_a); end
    step_n(5);
    checks++; if (lvl_a !== 3'd4) begin fails++; $display("FAIL full_held_level: got %0d want 4", lvl_a); end
    checks++; if (sr_a !== 1'b0)  begin fails++; $display("FAIL full_held_ready: got %b want 0", sr_a); end
    wait_tick_a(n);
    checks++; if (din_a !== 16'h1111) begin fails++; $display("FAIL full_pop1: got %h want 1111", din_a); end
    checks++; if (lvl_a !== 3'd3)     begin fails++; $display("FAIL full_nobypass: got %0d want 3", lvl_a); end
    step();
    sv_a = 1'b0;
    checks++; if (lvl_a !== 3'd4) begin fails++; $display("FAIL full_refill: got %0d want 4", lvl_a); end
    wait_tick_a(n);
    checks++; if (din_a !== 16'h2222) begin fails++; $display("FAIL full_pop2: got %h want 2222", din_a); end
    checks++; if (lvl_a !== 3'd3)     begin fails++; $display("FAIL full_level2: got %0d want 3", lvl_a); end
    step_n(1023);
    sv_a = 1'b1; sd_a = 16'h6666;
    #1;
    checks++; if (sr_a !== 1'b1) begin fails++; $display("FAIL full_ready_at_tick: got %b want 1", sr_a); end
    step();
    sv_a = 1'b0;
    checks++; if (tick_a !== 1'b1)    begin fails++; $display("FAIL full_tick3: got %b want 1", tick_a); end
    checks++; if (din_a !== 16'h3333) begin fails++; $display("FAIL full_pop3: got %h want 3333", din_a); end
    checks++; if (lvl_a !== 3'd3)     begin fails++; $display("FAIL full_pushpop_level: got %0d want 3", lvl_a); end
    wait_tick_a(n);
    checks++; if (din_a !== 16'h4444) begin fails++; $display("FAIL full_pop4: got %h want 4444", din_a); end
    checks++; if (lvl_a !== 3'd2)     begin fails++; $display("FAIL full_level4: got %0d want 2", lvl_a); end
  endtask

  task automatic test_mute();
    int n;
    bit ok;
    logic [15:0] exp_v;
    en_b = 1'b1;
    push_b(16'hFF00, ok);
    push_b(16'hFF00, ok);
    wait_tick_b(n);
    checks++; if (din_b !== 16'hFF00) begin fails++; $display("FAIL mute_start: got %h want ff00", din_b); end
    checks++; if (lvl_b !== 3'd1)     begin fails++; $display("FAIL mute_start_level: got %0d want 1", lvl_b); end
    en_b  = 1'b0;
    exp_v = 16'hFF00;
    for (int k = 1; k <= 127; k++) begin
      wait_tick_b(n);
      exp_v = exp_v - 16'd256;
      checks++;
      if (din_b !== exp_v) begin fails++; $display("FAIL mute_step %0d: got %h want %h", k, din_b, exp_v); end
      if (k == 1) begin
        checks++;
        if (n !== 16) begin fails++; $display("FAIL mute_first_period: got %0d want 16", n); end
      end
    end
    checks++; if (act_b !== 1'b1) begin fails++; $display("FAIL mute_still_ramp: got %b want 1", act_b); end
    checks++; if (lvl_b !== 3'd1) begin fails++; $display("FAIL mute_no_pop: got %0d want 1", lvl_b); end
    step();
    checks++; if (act_b !== 1'b0)     begin fails++; $display("FAIL mute_idle: got %b want 0", act_b); end
    checks++; if (lvl_b !== 3'd0)     begin fails++; $display("FAIL mute_flush: got %0d want 0", lvl_b); end
    checks++; if (din_b !== 16'h8000) begin fails++; $display("FAIL mute_mid: got %h want 8000", din_b); end
  endtask

  task automatic test_mute_short();
    int n;
    bit ok;
    en_b = 1'b1;
    push_b(16'h8050, ok);
    push_b(16'h8050, ok);
    wait_tick_b(n);
    checks++; if (din_b !== 16'h8050) begin fails++; $display("FAIL short_start: got %h want 8050", din_b); end
    en_b = 1'b0;
    step_n(2);
    en_b = 1'b1;
    #1;
    checks++; if (act_b !== 1'b1) begin fails++; $display("FAIL short_ramp_held: got %b want 1", act_b); end
    checks++; if (sr_b !== 1'b0)  begin fails++; $display("FAIL short_ramp_ready: got %b want 0", sr_b); end
    wait_tick_b(n);
    checks++; if (din_b !== 16'h8000) begin fails++; $display("FAIL short_clamp: got %h want 8000", din_b); end
    checks++; if (lvl_b !== 3'd1)     begin fails++; $display("FAIL short_prelevel: got %0d want 1", lvl_b); end
    step();
    checks++; if (act_b !== 1'b0) begin fails++; $display("FAIL short_idle: got %b want 0", act_b); end
    checks++; if (lvl_b !== 3'd0) begin fails++; $display("FAIL short_flush: got %0d want 0", lvl_b); end
    step();
    checks++; if (act_b !== 1'b0) begin fails++; $display("FAIL short_prime: got %b want 0", act_b); end
  endtask

  task automatic test_wrap();
    int urc;
    for (int i = 0; i < 1000; i++) wrap_data[i] = 16'($urandom);
    urc = 0;
    fork
      begin
        bit ok;
        for (int i = 0; i < 1000; i++) begin
          push_b(wrap_data[i], ok);
          if (!ok) break;
        end
      end
      begin
        int n;
        for (int i = 0; i < 1000; i++) begin
          wait_tick_b(n);
          if (n < 0) break;
          if (ur_b === 1'b1) urc++;
          checks++;
          if (din_b !== wrap_data[i]) begin fails++; $display("FAIL wrap_order %0d: got %h want %h", i, din_b, wrap_data[i]); end
        end
      end
    join
    checks++; if (urc !== 0) begin fails++; $display("FAIL wrap_underruns: got %0d want 0", urc); end
  endtask

  initial begin
    rst  = 1'b1;
    en_a = 1'b1; sv_a = 1'b0; sd_a = 16'h0000;
    en_b = 1'b0; sv_b = 1'b0; sd_b = 16'h0000;
    test_reset();
    test_startup();
    test_underrun();
    test_reset_midrun();
    test_full();
    test_mute();
    test_mute_short();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded 2 ms");
    $fatal(1);
  end

endmodule
